// File: rtl/button_debounce_pkg.sv
// Shared types and constants for the debounced pushbutton input cell.
package button_debounce_pkg;

  localparam int unsigned SYNC_STAGES = 2;
  localparam int unsigned PRESS_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE_LOW  = 2'd0,
    WAIT_HIGH = 2'd1,
    IDLE_HIGH = 2'd2,
    WAIT_LOW  = 2'd3
  } btn_state_e;

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous input bit.
module sync_2ff
  import button_debounce_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_debounce_in.sv
// Debounced pushbutton input with press/release pulses and a freeze input.
// Optional wrapping press counter enabled by BUTTON_DEBOUNCE_PRESS_CNT_EN.
module button_debounce_in
  import button_debounce_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic dis_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
`ifdef BUTTON_DEBOUNCE_PRESS_CNT_EN
  ,
  output logic [PRESS_CNT_W-1:0] press_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             btn_s2;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  sync_2ff u_sync (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .d_i   (btn_i),
    .q_o   (btn_s2)
  );

  // Disabled cycles leave every field at its held value, so a pending
  // count resumes exactly where it stopped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (!dis_i) begin
      unique case (state_q)
        IDLE_LOW: begin
          if (btn_s2) begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_HIGH: begin
          if (!btn_s2) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
            level_d = 1'b1;
            rise_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        IDLE_HIGH: begin
          if (!btn_s2) begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_ONE;
          end
        end
        WAIT_LOW: begin
          if (btn_s2) begin
            state_d = IDLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = IDLE_LOW;
            cnt_d   = '0;
            level_d = 1'b0;
            fall_d  = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE_LOW;
          cnt_d   = '0;
          level_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

`ifdef BUTTON_DEBOUNCE_PRESS_CNT_EN
  logic [PRESS_CNT_W-1:0] press_cnt_q;

  // Counts in step with the rise pulse; rise_d is already gated by dis_i.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      press_cnt_q <= '0;
    end else if (rise_d) begin
      press_cnt_q <= press_cnt_q + PRESS_CNT_W'(1);
    end
  end

  assign press_cnt_o = press_cnt_q;
`endif

endmodule

// File: tb/tb_button_debounce_in.sv
// Directed bench for button_debounce_in with STABLE_CYCLES=4.
module tb_button_debounce_in;

  logic clk;
  logic rst, dis, btn;
  logic level, rise, fall;
`ifdef BUTTON_DEBOUNCE_PRESS_CNT_EN
  logic [7:0] press_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  button_debounce_in #(.STABLE_CYCLES(4)) dut (
    .clk_i   (clk),
    .rst_i   (rst),
    .dis_i   (dis),
    .btn_i   (btn),
    .level_o (level),
    .rise_o  (rise),
    .fall_o  (fall)
`ifdef BUTTON_DEBOUNCE_PRESS_CNT_EN
    ,
    .press_cnt_o (press_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_chk(input string tag, input logic l, input logic r, input logic f);
    tick();
    check_eq({tag, ".level"}, 32'(level), 32'(l));
    check_eq({tag, ".rise"}, 32'(rise), 32'(r));
    check_eq({tag, ".fall"}, 32'(fall), 32'(f));
  endtask

  // From IDLE_LOW with btn just driven high: rise after the 6th edge.
  task automatic expect_rise(input string tag);
    for (int i = 1; i <= 7; i++)
      tick_chk(tag, i >= 6, i == 6, 1'b0);
  endtask

  task automatic expect_fall(input string tag);
    for (int i = 1; i <= 7; i++)
      tick_chk(tag, i < 6, 1'b0, i == 6);
  endtask

  initial begin
    rst = 1'b1;
    dis = 1'b0;
    btn = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) tick_chk("reset", 1'b0, 1'b0, 1'b0);
`ifdef BUTTON_DEBOUNCE_PRESS_CNT_EN
    check_eq("reset.press_cnt", 32'(press_cnt), 32'd0);
`endif
    rst = 1'b0;
    for (int i = 0; i < 20; i++) tick_chk("idle", 1'b0, 1'b0, 1'b0);

    // Clean press and release.
    btn = 1'b1;
    expect_rise("press");
    btn = 1'b0;
    expect_fall("release");

    // Bounce: 3 high, 1 low, 3 high, then low; never 4 consecutive samples.
    btn = 1'b1;
    for (int i = 0; i < 3; i++) tick_chk("bounce", 1'b0, 1'b0, 1'b0);
    btn = 1'b0;
    tick_chk("bounce", 1'b0, 1'b0, 1'b0);
    btn = 1'b1;
    for (int i = 0; i < 3; i++) tick_chk("bounce", 1'b0, 1'b0, 1'b0);
    btn = 1'b0;
    for (int i = 0; i < 8; i++) tick_chk("bounce", 1'b0, 1'b0, 1'b0);
    btn = 1'b1;
    expect_rise("bounce_ok");
    for (int i = 0; i < 4; i++) tick_chk("bounce_hold", 1'b1, 1'b0, 1'b0);
    btn = 1'b0;
    expect_fall("bounce_rel");

    // Disable after two counted samples (FSM counts at edges 2 and 3).
    btn = 1'b1;
    for (int i = 0; i < 4; i++) tick_chk("dis_pre", 1'b0, 1'b0, 1'b0);
    dis = 1'b1;
    for (int i = 0; i < 5; i++) tick_chk("dis_hold", 1'b0, 1'b0, 1'b0);
    dis = 1'b0;
    tick_chk("dis_resume1", 1'b0, 1'b0, 1'b0);
    tick_chk("dis_resume2", 1'b1, 1'b1, 1'b0);
    tick_chk("dis_after", 1'b1, 1'b0, 1'b0);

    // Frozen while high: a long low level does not complete a release.
    dis = 1'b1;
    btn = 1'b0;
    for (int i = 0; i < 8; i++) tick_chk("dis_high", 1'b1, 1'b0, 1'b0);
    btn = 1'b1;
    dis = 1'b0;
    for (int i = 0; i < 4; i++) tick_chk("dis_high_end", 1'b1, 1'b0, 1'b0);

    // Reset while level is high and btn stays high.
    rst = 1'b1;
    tick_chk("midrst", 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    expect_rise("midrst_rise");
    btn = 1'b0;
    expect_fall("midrst_rel");

`ifdef BUTTON_DEBOUNCE_PRESS_CNT_EN
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("pc.reset", 32'(press_cnt), 32'd0);
    for (int p = 0; p < 257; p++) begin
      btn = 1'b1;
      for (int i = 0; i < 7; i++) tick();
      btn = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      if (p == 0) check_eq("pc.first", 32'(press_cnt), 32'd1);
      if (p == 255) check_eq("pc.wrap", 32'(press_cnt), 32'd0);
    end
    btn = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    btn = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    check_eq("pc.final", 32'(press_cnt), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
